demux16_fifo_router: RTL and testbench
======================================

Name: demux16_fifo_router

Overview:
- Registered, flow-controlled 1-to-2 data router. Sits directly downstream of the 16-bit select stage in the datapath.
- Accepts one 16-bit word per cycle with a channel select. Steers the word into one of two independent per-channel FIFOs.
- Presents each FIFO head on its own valid/ready output port, so the two consumers can stall independently without losing data.
- Order is preserved within each channel.

Parameters:
- WIDTH, 16, data word width.
- DEPTH, 2, entries per channel FIFO. Power of two, ≥2.
- CW, $clog2(DEPTH+1), occupancy counter width. Derived; do not override.

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream word valid.
- in_ready  out  1  selected channel can accept.
- A  in  WIDTH  upstream data word.
- sel  in  1  target channel: 0→Y0 path, 1→Y1 path.
- y0_valid  out  1  channel-0 FIFO non-empty.
- y0_ready  in  1  channel-0 consumer accepts.
- Y0  out  WIDTH  channel-0 head word.
- y1_valid  out  1  channel-1 FIFO non-empty.
- y1_ready  in  1  channel-1 consumer accepts.
- Y1  out  WIDTH  channel-1 head word.
- y0_count  out  CW  channel-0 occupancy.
- y1_count  out  CW  channel-1 occupancy.

Behaviour:
- Reset:
  - rst_n low clears, asynchronously, all read/write pointers and both counts to 0.
  - y0_valid=y1_valid=0; Y0=Y1=0; in_ready=1.
  - Storage contents need not be cleared.
  - Reset asserted mid-transfer discards all buffered words. No partial state survives.
- Push: occurs on a rising edge when in_valid && in_ready. A is written to FIFO[sel] and that FIFO's write pointer increments modulo DEPTH.
- in_ready: combinational, = sel ? (y1_count!=DEPTH) : (y0_count!=DEPTH). It may depend on sel but never on in_valid.
- Pop: channel k pops on a rising edge when yk_valid && yk_ready. Its read pointer increments modulo DEPTH.
- Outputs:
  - yk_valid = (yk_count != 0). Registered state, no combinational path from in_valid.
  - Yk = mem_k[rd_ptr_k] while yk_valid=1; 0 while empty.
- Latency: a word pushed at edge N is visible on Yk with yk_valid=1 immediately after edge N, i.e. a 1-cycle latency. No input-to-output combinational bypass.
- Simultaneous push and pop on the same channel: legal whenever not full. The count is unchanged and the head advances correctly. When count=DEPTH, the push is blocked by in_ready=0 even if the same-cycle pop would free a slot; there is no full pass-through.
- Push on one channel with a pop on the other: fully independent.
- Wrap-around: pointers wrap modulo DEPTH with no gap or duplication across the wrap.
- Count: yk_count = pushes − pops since reset. It saturates structurally at 0..DEPTH; it never underflows or overflows.
- Stall on one channel never blocks the other channel when sel targets the non-full one.
- in_valid without in_ready: the word is not taken. Upstream holds A/sel stable until accepted; the router does not check this.
- Unknown sel while in_valid=0 has no effect.

Test Plan:
- Reset then idle → y0_valid=y1_valid=0, Y0=Y1=0, counts=0, in_ready=1. Assert rst_n low mid-operation with count0=2 → count0=0 and y0_valid=0 immediately, without waiting for a clock.
- Push A=16'h1234 sel=0, then A=16'hABCD sel=1, with both readies high → Y0=1234 valid one cycle after the first edge; Y1=ABCD valid after the second; each pops the next cycle; counts return to 0.
- Hold y0_ready=0 and push 16'h0001, 16'h0002 to sel=0 → y0_count=2, in_ready=0 for sel=0. A third push of 16'h0003 is not accepted. With sel=1 in the same state, in_ready=1 and 16'h00FF enters channel 1.
- Full channel 0, then set y0_ready=1 with in_valid=1 sel=0 → pop of 0001 only, no push that cycle. The next cycle accepts 0003. Drain order is 0002 then 0003.
- With count0=1, push and pop channel 0 in the same cycle for 8 consecutive words 16'h0010..16'h0017 → count0 stays 1, pointers wrap 4 times, and output order matches exactly.
- Random sel/valid/ready for 10k cycles against a scoreboard model → no loss, duplication or reordering per channel; counts match the model every cycle.

Source files
------------

// File: rtl/demux16_fifo_router.sv
// 1-to-2 word router with an independent FIFO per output channel.
// Each channel drains on its own valid/ready port; order kept per channel.
module demux16_fifo_router #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 2,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic             sel,
  output logic             y0_valid,
  input  logic             y0_ready,
  output logic [WIDTH-1:0] Y0,
  output logic             y1_valid,
  input  logic             y1_ready,
  output logic [WIDTH-1:0] Y1,
  output logic [CW-1:0]    y0_count,
  output logic [CW-1:0]    y1_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] PONE = PW'(1);
  localparam logic [CW-1:0] CONE = CW'(1);

  logic [WIDTH-1:0] mem0_q [DEPTH];
  logic [WIDTH-1:0] mem1_q [DEPTH];

  logic [PW-1:0] wr0_q, wr0_d;
  logic [PW-1:0] rd0_q, rd0_d;
  logic [PW-1:0] wr1_q, wr1_d;
  logic [PW-1:0] rd1_q, rd1_d;
  logic [CW-1:0] cnt0_q, cnt0_d;
  logic [CW-1:0] cnt1_q, cnt1_d;

  logic push0, push1;
  logic pop0, pop1;
  logic full0, full1;

  // A full channel refuses even if it pops this cycle: no pass-through.
  assign full0    = (cnt0_q == FULL);
  assign full1    = (cnt1_q == FULL);
  assign in_ready = sel ? !full1 : !full0;

  assign push0 = in_valid && !sel && !full0;
  assign push1 = in_valid &&  sel && !full1;

  assign y0_valid = (cnt0_q != '0);
  assign y1_valid = (cnt1_q != '0);

  assign pop0 = y0_valid && y0_ready;
  assign pop1 = y1_valid && y1_ready;

  assign Y0 = y0_valid ? mem0_q[rd0_q] : '0;
  assign Y1 = y1_valid ? mem1_q[rd1_q] : '0;

  assign y0_count = cnt0_q;
  assign y1_count = cnt1_q;

  always_comb begin
    wr0_d  = wr0_q;
    rd0_d  = rd0_q;
    cnt0_d = cnt0_q;
    if (push0) wr0_d = wr0_q + PONE;
    if (pop0)  rd0_d = rd0_q + PONE;
    unique case ({push0, pop0})
      2'b10:   cnt0_d = cnt0_q + CONE;
      2'b01:   cnt0_d = cnt0_q - CONE;
      default: cnt0_d = cnt0_q;
    endcase
  end

  always_comb begin
    wr1_d  = wr1_q;
    rd1_d  = rd1_q;
    cnt1_d = cnt1_q;
    if (push1) wr1_d = wr1_q + PONE;
    if (pop1)  rd1_d = rd1_q + PONE;
    unique case ({push1, pop1})
      2'b10:   cnt1_d = cnt1_q + CONE;
      2'b01:   cnt1_d = cnt1_q - CONE;
      default: cnt1_d = cnt1_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr0_q  <= '0;
      rd0_q  <= '0;
      cnt0_q <= '0;
      wr1_q  <= '0;
      rd1_q  <= '0;
      cnt1_q <= '0;
    end else begin
      wr0_q  <= wr0_d;
      rd0_q  <= rd0_d;
      cnt0_q <= cnt0_d;
      wr1_q  <= wr1_d;
      rd1_q  <= rd1_d;
      cnt1_q <= cnt1_d;
    end
  end

  // Storage is left uncleared; counts alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push0) mem0_q[wr0_q] <= A;
    if (push1) mem1_q[wr1_q] <= A;
  end

endmodule

// File: tb/tb_demux16_fifo_router.sv
// Bench for demux16_fifo_router: directed cases plus random traffic
// against a per-channel queue model.
module tb_demux16_fifo_router;

  localparam int WIDTH = 16;
  localparam int DEPTH = 2;
  localparam int CW    = $clog2(DEPTH+1);

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic             sel;
  logic             y0_valid;
  logic             y0_ready;
  logic [WIDTH-1:0] Y0;
  logic             y1_valid;
  logic             y1_ready;
  logic [WIDTH-1:0] Y1;
  logic [CW-1:0]    y0_count;
  logic [CW-1:0]    y1_count;

  int total = 0;
  int bad   = 0;

  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];

  demux16_fifo_router #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (A),
    .sel      (sel),
    .y0_valid (y0_valid),
    .y0_ready (y0_ready),
    .Y0       (Y0),
    .y1_valid (y1_valid),
    .y1_ready (y1_ready),
    .Y1       (Y1),
    .y0_count (y0_count),
    .y1_count (y1_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outs();
    logic [WIDTH-1:0] h0, h1;
    h0 = (q0.size() > 0) ? q0[0] : '0;
    h1 = (q1.size() > 0) ? q1[0] : '0;
    check("y0_valid", 32'(y0_valid), 32'(q0.size() != 0));
    check("y1_valid", 32'(y1_valid), 32'(q1.size() != 0));
    check("Y0",       32'(Y0),       32'(h0));
    check("Y1",       32'(Y1),       32'(h1));
    check("y0_count", 32'(y0_count), 32'(q0.size()));
    check("y1_count", 32'(y1_count), 32'(q1.size()));
  endtask

  // Entered 1 time unit after a rising edge; leaves at the same phase.
  task automatic step(input logic v, input logic [WIDTH-1:0] a,
                      input logic s, input logic r0, input logic r1);
    bit room, push, pop0, pop1;
    in_valid = v;
    A        = a;
    sel      = s;
    y0_ready = r0;
    y1_ready = r1;
    #1;
    room = s ? (q1.size() < DEPTH) : (q0.size() < DEPTH);
    check("in_ready", 32'(in_ready), 32'(room));
    push = v && room;
    pop0 = r0 && (q0.size() > 0);
    pop1 = r1 && (q1.size() > 0);
    @(posedge clk);
    #1;
    if (pop0) void'(q0.pop_front());
    if (pop1) void'(q1.pop_front());
    if (push) begin
      if (s) q1.push_back(a);
      else   q0.push_back(a);
    end
    check_outs();
  endtask

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b0;
    A        = '0;
    sel      = 1'b0;
    y0_ready = 1'b0;
    y1_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check_outs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outs();

    // Basic routing to both channels.
    step(1'b1, 16'h1234, 1'b0, 1'b1, 1'b1);
    check("y0_first", 32'(Y0), 32'h1234);
    step(1'b1, 16'hABCD, 1'b1, 1'b1, 1'b1);
    check("y1_first", 32'(Y1), 32'hABCD);
    check("y0_drained", 32'(y0_count), 32'd0);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    check("y1_drained", 32'(y1_count), 32'd0);

    // Fill channel 0, blocked push, other channel still open.
    step(1'b1, 16'h0001, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'h0002, 1'b0, 1'b0, 1'b0);
    check("full_cnt", 32'(y0_count), 32'd2);
    step(1'b1, 16'h0003, 1'b0, 1'b0, 1'b0);
    check("blocked_cnt", 32'(y0_count), 32'd2);
    check("blocked_head", 32'(Y0), 32'h0001);
    step(1'b1, 16'h00FF, 1'b1, 1'b0, 1'b0);
    check("other_ch", 32'(Y1), 32'h00FF);

    // Full channel pops but refuses the same-cycle push.
    step(1'b1, 16'h0003, 1'b0, 1'b1, 1'b0);
    check("nopass_cnt", 32'(y0_count), 32'd1);
    check("nopass_head", 32'(Y0), 32'h0002);
    step(1'b1, 16'h0003, 1'b0, 1'b1, 1'b0);
    check("drain_2nd", 32'(Y0), 32'h0003);
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
    check("drain_done", 32'(y0_count), 32'd0);

    // Steady push+pop at count 1 across several wraps.
    step(1'b1, 16'h000F, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 16'(16'h0010 + i), 1'b0, 1'b1, 1'b0);
      check("wrap_cnt", 32'(y0_count), 32'd1);
      check("wrap_head", 32'(Y0), 32'(16'h0010 + i));
    end
    step(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);

    // Asynchronous reset with buffered words.
    step(1'b1, 16'h5A5A, 1'b0, 1'b0, 1'b0);
    step(1'b1, 16'hA5A5, 1'b0, 1'b0, 1'b0);
    check("pre_rst_cnt", 32'(y0_count), 32'd2);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_cnt", 32'(y0_count), 32'd0);
    check("async_valid", 32'(y0_valid), 32'd0);
    check("async_Y0", 32'(Y0), 32'd0);
    q0.delete();
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_outs();

    // Random traffic.
    for (int n = 0; n < 10000; n++) begin
      step(1'($urandom_range(0, 1)), 16'($urandom),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
